// File: rtl/exu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exu_mdu : iterative RV32M multiply/divide unit with valid/ready handshake. |
// | Define MDU_FAST_MUL_EN for a single-cycle combinational multiply path.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module exu_mdu #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_rd_wen,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_rd_wen,
    output logic [4:0]      o_rd_addr,
    output logic            o_busy
);

    localparam int c_CNT_W = $clog2(XLEN) + 1;
`ifdef MDU_FAST_MUL_EN
    localparam int c_MUL_ITER = 1;
`else
    localparam int c_MUL_ITER = XLEN / MUL_BPC;
`endif
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(c_MUL_ITER - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]    c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]          r_state, w_state_nxt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg_q, r_neg_r;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]     r_result;
    logic                r_rd_wen;
    logic [4:0]          r_rd_addr;

    logic                w_accept, w_special, w_last, w_mul_in, w_mul;
    logic                w_sa, w_sb, w_div0, w_ovf;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_spec_res;
    logic [2*XLEN-1:0]   w_mul_step, w_div_step, w_step, w_prod;
    logic [XLEN:0]       w_rem_sh, w_diff;
    logic [XLEN-1:0]     w_lo, w_hi, w_quo, w_rem, w_final;

    // Accept-time decode: signedness, magnitudes and the divide corner cases
    assign w_mul_in   = ~i_op[2];
    assign w_sa       = i_rs1[XLEN-1] & (i_op == 3'd0 || i_op == 3'd1 || i_op == 3'd2 ||
                                         i_op == 3'd4 || i_op == 3'd6);
    assign w_sb       = i_rs2[XLEN-1] & (i_op == 3'd0 || i_op == 3'd1 ||
                                         i_op == 3'd4 || i_op == 3'd6);
    assign w_mag_a    = w_sa ? -i_rs1 : i_rs1;
    assign w_mag_b    = w_sb ? -i_rs2 : i_rs2;
    assign w_div0     = i_op[2] & (i_rs2 == '0);
    assign w_ovf      = i_op[2] & ~i_op[0] & (i_rs1 == c_INT_MIN) & (&i_rs2);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (i_op[1] ? i_rs1 : '1) : (i_op[1] ? '0 : i_rs1);

    assign o_ready  = (r_state == c_S_IDLE) & ~i_flush;
    assign w_accept = i_valid & o_ready;
    assign w_mul    = ~r_op[2];
    assign w_last   = (r_cnt == (w_mul ? c_MUL_LAST : c_DIV_LAST));

`ifdef MDU_FAST_MUL_EN
    assign w_mul_step = {{XLEN{1'b0}}, r_opnd} * {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
`else
    // Multiplier sits in the low half and shifts out MUL_BPC bits per step
    logic [XLEN+MUL_BPC-1:0] w_mul_sum;
    always_comb begin
        w_mul_sum = {{MUL_BPC{1'b0}}, r_acc[2*XLEN-1:XLEN]};
        for (int k = 0; k < MUL_BPC; k++) begin
            if (r_acc[k]) begin
                w_mul_sum = w_mul_sum + ({{MUL_BPC{1'b0}}, r_opnd} << k);
            end
        end
    end
    assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:MUL_BPC]};
`endif

    // Restoring divide: remainder in the high half, dividend/quotient in the low half
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_step = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

    assign w_step = w_mul ? w_mul_step : w_div_step;
    assign w_prod = r_neg_q ? -w_step : w_step;
    assign w_lo   = w_step[XLEN-1:0];
    assign w_hi   = w_step[2*XLEN-1:XLEN];
    assign w_quo  = r_neg_q ? -w_lo : w_lo;
    assign w_rem  = r_neg_r ? -w_hi : w_hi;

    always_comb begin
        w_final = w_rem;
        case (r_op)
            3'd0:                w_final = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_final = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_final = w_quo;
            default:             w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept) w_state_nxt = w_special ? c_S_DONE : c_S_CALC;
            c_S_CALC: if (w_last)   w_state_nxt = c_S_DONE;
            c_S_DONE: if (i_ready)  w_state_nxt = c_S_IDLE;
            default:                w_state_nxt = c_S_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = c_S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_rd_wen  <= 1'b0;
            r_rd_addr <= '0;
        end else if (w_accept) begin
            r_op      <= i_op;
            r_opnd    <= w_mul_in ? w_mag_a : w_mag_b;
            r_acc     <= {{XLEN{1'b0}}, (w_mul_in ? w_mag_b : w_mag_a)};
            r_neg_q   <= w_sa ^ w_sb;
            r_neg_r   <= w_sa;
            r_cnt     <= '0;
            r_rd_wen  <= i_rd_wen;
            r_rd_addr <= i_rd_addr;
            if (w_special) begin
                r_result <= w_spec_res;
            end
        end else if (r_state == c_S_CALC && !i_flush) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign o_valid   = (r_state == c_S_DONE);
    assign o_busy    = (r_state != c_S_IDLE);
    assign o_result  = r_result;
    assign o_rd_wen  = r_rd_wen;
    assign o_rd_addr = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_exu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exu_mdu : scoreboard bench for exu_mdu with a longint reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_exu_mdu;

    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int c_MUL_LAT = 2;
`else
    localparam int c_MUL_LAT = XLEN + 1;
`endif
    localparam int c_DIV_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [2:0]      i_op = '0;
    logic [XLEN-1:0] i_rs1 = '0;
    logic [XLEN-1:0] i_rs2 = '0;
    logic            i_rd_wen = 1'b0;
    logic [4:0]      i_rd_addr = '0;
    logic            i_flush = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [XLEN-1:0] o_result;
    logic            o_rd_wen;
    logic [4:0]      o_rd_addr;
    logic            o_busy;

    exu_mdu #(.XLEN(XLEN), .MUL_BPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd_wen(i_rd_wen),
        .i_rd_addr(i_rd_addr), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_rd_wen(o_rd_wen),
        .o_rd_addr(o_rd_addr), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        wen;
        logic [4:0]  addr;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p; return r[31:0]; end
            3'd1: begin p = sa * sb; r = p; return r[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p; return r[63:32]; end
            3'd3: begin up = ua * ub; r = up; return r[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; r = p; return r[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; r = up; return r[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; r = p; return r[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; r = up; return r[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return c_MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return c_DIV_LAT;
    endfunction

    // Issue one request and push its expected response once the accept edge has passed
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res);
        exp_t e;
        int   n;
        @(negedge clk);
        i_valid   = 1'b1;
        i_op      = op;
        i_rs1     = a;
        i_rs2     = b;
        i_rd_wen  = 1'($urandom_range(0, 1));
        i_rd_addr = 5'($urandom_range(0, 31));
        #1;
        n = 0;
        while (!o_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!o_ready) begin
            chk("accept_timeout", 32'(o_ready), 32'd1);
            i_valid = 1'b0;
            return;
        end
        e.res  = exp_res;
        e.wen  = i_rd_wen;
        e.addr = i_rd_addr;
        e.lat  = ref_lat(op, a, b);
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        #2;
        while ((q.size() != 0 || o_valid) && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 400) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            i_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops on the first cycle of each result, then checks it stays put
    initial begin
        exp_t cur;
        bit   seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (o_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 32'(o_valid), 32'd0);
                        cur.res = o_result; cur.wen = o_rd_wen; cur.addr = o_rd_addr;
                    end else begin
                        cur = q.pop_front();
                        chk("result", o_result, cur.res);
                        chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    end
                    seen = 1'b1;
                end else begin
                    chk("hold_result", o_result, cur.res);
                end
                chk("rd_wen", 32'(o_rd_wen), 32'(cur.wen));
                chk("rd_addr", 32'(o_rd_addr), 32'(cur.addr));
                chk("ready_low_in_done", 32'(o_ready), 32'd0);
                if (i_ready || i_flush) seen = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_result", o_result, 32'd0);
        chk("reset_rd_wen", 32'(o_rd_wen), 32'd0);
        chk("reset_rd_addr", 32'(o_rd_addr), 32'd0);
        rst_n = 1'b1;

        // Directed values with hand-derived answers
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        issue(3'd7, 32'd100, 32'd7, 32'd2);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        issue(3'd6, 32'd5, 32'd0, 32'd5);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        drain();

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, ref_mdu(op, a, b));
        end
        drain();

        // Flush mid-divide; a same-cycle request must be ignored
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd7;
        #1;
        n = 0;
        while (!o_ready && n < 100) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        i_flush = 1'b1; i_valid = 1'b1; i_op = 3'd0;
        #1;
        chk("flush_blocks_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        i_flush = 1'b0; i_valid = 1'b0;
        #1;
        chk("flush_ready", 32'(o_ready), 32'd1);
        chk("flush_busy", 32'(o_busy), 32'd0);
        chk("flush_valid", 32'(o_valid), 32'd0);
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        drain();

        // Back-pressure: result and destination must hold while unconsumed
        hold_ready = 1'b1;
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        n = 0;
        while (!o_valid && n < 100) begin @(negedge clk); n++; end
        if (!o_valid) chk("bp_valid_timeout", 32'(o_valid), 32'd1);
        repeat (5) @(negedge clk);
        hold_ready = 1'b0;
        drain();

        // Asynchronous reset mid-operation discards the op at once
        issue(3'd5, 32'hFFFF_0000, 32'd3, 32'h5555_0000);
        repeat (6) @(negedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("areset_busy", 32'(o_busy), 32'd0);
        chk("areset_valid", 32'(o_valid), 32'd0);
        chk("areset_ready", 32'(o_ready), 32'd1);
        chk("areset_result", o_result, 32'd0);
        chk("areset_rd_addr", 32'(o_rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd7, 32'd1234567, 32'd1000, 32'd567);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
